// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised register file with multiple combinational read ports and a walk-clear FSM
// Optional same-cycle write-through read forwarding is enabled by defining REGFILE_PARAM_BYPASS_EN.
module regfile_param #(
  parameter int          DATA_W    = 8,
  parameter int          ADDR_W    = 4,
  parameter int          NUM_RD    = 2,
  parameter logic [31:0] RESET_VAL = 32'hF0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0]        top_out,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_drop
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] RST_V = RESET_VAL[DATA_W-1:0];

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   ptr, ptr_nx;
  logic                drop_nx;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: RST_V};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      wr_drop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_V;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      wr_drop <= drop_nx;
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
  end

  // The clear walk owns the single write port; user writes are only honoured in IDLE.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    drop_nx   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state)
      IDLE: begin
        mem_we = wr_en;
        if (clr_req) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = RST_V;
        ptr_nx    = ptr + 1'b1;
        drop_nx   = wr_en;
        if (&ptr) state_nx = IDLE;
      end
    endcase
  end

  assign clr_busy = (state == CLEAR);
  assign top_out  = mem[DEPTH-1];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_PARAM_BYPASS_EN
    // Forward only writes that will actually commit this cycle.
    assign rd_data[k*DATA_W +: DATA_W] =
      (!rst && state == IDLE && wr_en && wr_addr == ra) ? wr_data : mem[ra];
`else
    assign rd_data[k*DATA_W +: DATA_W] = mem[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (default build and 16b/8-entry/4-port build)
module tb_regfile_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, clr_req, clr_busy, wr_drop;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data, top_out;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;

  logic        rst1, wr_en1, clr_req1, clr_busy1, wr_drop1;
  logic [2:0]  wr_addr1;
  logic [15:0] wr_data1, top_out1;
  logic [11:0] rd_addr1;
  logic [63:0] rd_data1;

  regfile_param dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .top_out(top_out),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .top_out(top_out1),
    .clr_req(clr_req1), .clr_busy(clr_busy1), .wr_drop(wr_drop1)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: array contents, remaining clear cycles, pending drop flag
  logic [7:0] m_mem [16];
  int         m_left = 0;
  bit         m_drop = 1'b0;

  typedef struct {
    logic       r, we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       cr;
    logic [3:0] ra0, ra1;
    logic [7:0] e0, e1, etop;
    logic       ebusy, edrop;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    exp_rd = m_mem[a];
`ifdef REGFILE_PARAM_BYPASS_EN
    if (!rst && m_left == 0 && wr_en && wr_addr == a) exp_rd = wr_data;
`endif
  endfunction

  task automatic model_check();
    chk("rd0", rd_data[7:0], exp_rd(rd_addr[3:0]));
    chk("rd1", rd_data[15:8], exp_rd(rd_addr[7:4]));
    chk("top_out", top_out, m_mem[15]);
    chk("clr_busy", clr_busy, m_left > 0);
    chk("wr_drop", wr_drop, m_drop);
  endtask

  task automatic model_adv();
    @(posedge clk);
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 8'hF0;
      m_left = 0;
      m_drop = 1'b0;
    end else if (m_left > 0) begin
      m_drop = wr_en;
      m_mem[16 - m_left] = 8'hF0;
      m_left--;
    end else begin
      m_drop = 1'b0;
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (clr_req) m_left = 16;
    end
    #1;
  endtask

  task automatic step0();
    @(negedge clk);
    model_check();
    model_adv();
  endtask

  task automatic drive(input logic r, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic cr, input logic [3:0] ra0, input logic [3:0] ra1);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; clr_req = cr; rd_addr = {ra1, ra0};
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i), 8'(base + 8'(i * 3)), 1'b0, 4'(i), 4'(15 - i));
      step0();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, busy_seen;
    logic [15:0] byp5a, bypbeef;

    foreach (m_mem[i]) m_mem[i] = 8'hF0;
    drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0);
    rst1 = 1'b1; wr_en1 = 1'b0; clr_req1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; rd_addr1 = '0;
    model_adv();

    tbl[0] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  4'd15, 8'hF0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'd3,  8'h5A, 1'b0, 4'd4,  4'd15, 8'hF0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'd15, 8'h11, 1'b0, 4'd3,  4'd0,  8'h5A, 8'hF0, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd15, 4'd15, 8'h11, 8'h11, 8'h11, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4'd0,  8'h22, 1'b0, 4'd3,  4'd15, 8'h5A, 8'h11, 8'h11, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'd1,  8'h33, 1'b0, 4'd0,  4'd1,  8'h22, 8'hF0, 8'h11, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  4'd3,  8'hF0, 8'hF0, 8'hF0, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].r, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].cr, tbl[i].ra0, tbl[i].ra1);
      @(negedge clk);
      chk("tbl_rd0", rd_data[7:0], tbl[i].e0);
      chk("tbl_rd1", rd_data[15:8], tbl[i].e1);
      chk("tbl_top", top_out, tbl[i].etop);
      chk("tbl_busy", clr_busy, tbl[i].ebusy);
      chk("tbl_drop", wr_drop, tbl[i].edrop);
      model_check();
      model_adv();
    end

    // Same-cycle read of a write, then the following cycle
    drive(1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, 4'd3, 4'd3);
    @(negedge clk);
`ifdef REGFILE_PARAM_BYPASS_EN
    chk("same_cycle_rd", rd_data[7:0], 8'h5A);
`else
    chk("same_cycle_rd", rd_data[7:0], 8'hF0);
`endif
    model_check();
    model_adv();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 4'd2);
    @(negedge clk);
    chk("next_cycle_rd", rd_data[7:0], 8'h5A);
    model_check();
    model_adv();

    // Full walk with a dropped write at clear cycle 5 and a repeated clr_req at cycle 9
    fill(8'h10);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 4'd0);
    step0();
    busy_seen = 0;
    for (int c = 0; c < 24; c++) begin
      idx = (m_left > 0) ? 16 - m_left : -1;
      drive(1'b0, idx == 5, 4'd2, 8'h77, idx == 9,
            (idx > 0) ? 4'(idx - 1) : 4'd0, (idx >= 0) ? 4'(idx) : 4'd15);
      @(negedge clk);
      if (clr_busy) busy_seen++;
      if (idx == 6) chk("drop_pulse", wr_drop, 1'b1);
      if (idx == 7) chk("drop_one_cycle", wr_drop, 1'b0);
      if (idx > 0) chk("walk_cleared", rd_data[7:0], 8'hF0);
      if (idx >= 0) chk("walk_retained", rd_data[15:8], 8'(8'h10 + 8'(idx * 3)));
      model_check();
      model_adv();
    end
    chk("clr_len", busy_seen, 16);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd2, 4'd15);
    @(negedge clk);
    chk("dropped_entry", rd_data[7:0], 8'hF0);
    model_check();
    model_adv();

    // Reset at clear cycle 8 aborts the walk
    fill(8'h80);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 4'd0);
    step0();
    for (int c = 0; c < 9; c++) begin
      drive(c == 8, 1'b0, 4'd0, 8'h00, 1'b0, 4'(c), 4'(c + 1));
      step0();
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd9, 4'd12);
    @(negedge clk);
    chk("rst_abort_busy", clr_busy, 1'b0);
    model_check();
    model_adv();
    for (int j = 0; j < 8; j++) begin
      drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'(2 * j), 4'(2 * j + 1));
      @(negedge clk);
      chk("rst_entry_even", rd_data[7:0], 8'hF0);
      chk("rst_entry_odd", rd_data[15:8], 8'hF0);
      model_check();
      model_adv();
    end

    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 64) == 0, 1'($urandom), 4'($urandom), 8'($urandom),
            ($urandom % 24) == 0, 4'($urandom), 4'($urandom));
      step0();
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0);

    // Wide, shallow, four-port build
`ifdef REGFILE_PARAM_BYPASS_EN
    byp5a = 16'h005A; bypbeef = 16'hBEEF;
`else
    byp5a = 16'h00F0; bypbeef = 16'h00F0;
`endif
    rst1 = 1'b0; wr_en1 = 1'b1; wr_addr1 = 3'd3; wr_data1 = 16'h005A;
    rd_addr1 = {3'd0, 3'd3, 3'd7, 3'd3};
    @(negedge clk);
    chk("w_p0_a", rd_data1[15:0], byp5a);
    chk("w_p1_a", rd_data1[31:16], 16'h00F0);
    chk("w_p2_a", rd_data1[47:32], byp5a);
    chk("w_p3_a", rd_data1[63:48], 16'h00F0);
    chk("w_top_a", top_out1, 16'h00F0);
    @(posedge clk); #1;
    wr_addr1 = 3'd7; wr_data1 = 16'hBEEF; rd_addr1 = {3'd2, 3'd7, 3'd3, 3'd3};
    @(negedge clk);
    chk("w_p0_b", rd_data1[15:0], 16'h005A);
    chk("w_p1_b", rd_data1[31:16], 16'h005A);
    chk("w_p2_b", rd_data1[47:32], bypbeef);
    chk("w_p3_b", rd_data1[63:48], 16'h00F0);
    chk("w_top_b", top_out1, 16'h00F0);
    @(posedge clk); #1;
    wr_en1 = 1'b0; rd_addr1 = {3'd7, 3'd0, 3'd3, 3'd7};
    @(negedge clk);
    chk("w_p0_c", rd_data1[15:0], 16'hBEEF);
    chk("w_p1_c", rd_data1[31:16], 16'h005A);
    chk("w_p2_c", rd_data1[47:32], 16'h00F0);
    chk("w_p3_c", rd_data1[63:48], 16'hBEEF);
    chk("w_top_c", top_out1, 16'hBEEF);
    chk("w_busy", clr_busy1, 1'b0);
    chk("w_drop", wr_drop1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits (1..32).
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter RESET_VAL, default 'hF0 truncated/zero-extended to DATA_W, reset and clear value of every entry.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  write request for the current cycle.
REQ-008 wr_addr  input  ADDR_W  write target entry.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-011 rd_data  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-012 top_out  output  DATA_W  contents of entry DEPTH-1.
REQ-013 clr_req  input  1  request to walk-clear the whole array.
REQ-014 clr_busy  output  1  high while the clear walk is in progress.
REQ-015 wr_drop  output  1  one-cycle pulse flagging a write rejected during clear.

Function
REQ-016 Read ports SHALL be combinational: rd_data[k] = entry[rd_addr[k]] in the same cycle, zero-latency.
REQ-017 top_out SHALL be combinational from entry DEPTH-1 and SHALL never use bypass.
REQ-018 FSM SHALL have two states: IDLE and CLEAR.
REQ-019 In IDLE, wr_en=1 SHALL write wr_data to entry wr_addr on the rising edge; visible to reads the next cycle.
REQ-020 In IDLE, clr_req=1 SHALL move to CLEAR next cycle with clear pointer = 0.
REQ-021 In CLEAR, each cycle SHALL write RESET_VAL to entry[pointer] and increment pointer; after writing entry DEPTH-1 the FSM SHALL return to IDLE the next cycle (CLEAR lasts exactly DEPTH cycles).
REQ-022 clr_busy SHALL equal 1 exactly in CLEAR.
REQ-023 clr_req in CLEAR SHALL be ignored; the walk does not restart.
REQ-024 wr_en=1 in CLEAR SHALL be discarded (no array change) and wr_drop SHALL be 1 the following cycle only.
REQ-025 wr_en=1 and clr_req=1 together in IDLE SHALL commit the write in that cycle, then start CLEAR (write later overwritten by walk).
REQ-026 Multiple read ports addressing the same entry SHALL all return identical data.
REQ-027 Reads during CLEAR SHALL return current array contents (partially cleared) with no bypass.

Reset
REQ-028 rst=1 at a rising edge SHALL set every entry to RESET_VAL in that cycle, FSM to IDLE, pointer to 0, clr_busy to 0, wr_drop to 0.
REQ-029 rst SHALL take priority over wr_en, clr_req and an in-progress CLEAR (walk aborted).
REQ-030 After reset, all rd_data ports and top_out SHALL read RESET_VAL.
REQ-031 Entries SHALL also power up at RESET_VAL for simulation.

Configuration
REQ-032 Macro REGFILE_PARAM_BYPASS_EN defined: in IDLE, if wr_en=1 and wr_addr == rd_addr[k], rd_data[k] SHALL equal wr_data in the same cycle (write-through forwarding), per port independently.
REQ-033 Macro REGFILE_PARAM_BYPASS_EN undefined: rd_data[k] SHALL return the pre-write array value in the write cycle; new value visible next cycle.

Verification
REQ-034 Default params, rst 1 cycle -> all read ports and top_out = 8'hF0, clr_busy=0, wr_drop=0.
REQ-035 Write 8'h5A to addr 3, read port0 addr 3 same cycle -> 8'h5A with BYPASS_EN, 8'hF0 without; next cycle 8'h5A in both builds.
REQ-036 Write 8'h11 to addr 15 -> top_out = 8'h11 next cycle; port1 reading addr 15 matches.
REQ-037 Fill all entries with distinct values, pulse clr_req -> clr_busy high exactly 16 cycles; during walk entries 0..n read 8'hF0 and n+1..15 retain values; after walk all 8'hF0.
REQ-038 wr_en to addr 2 with 8'h77 at clear cycle 5 -> wr_drop=1 one cycle, entry 2 = 8'hF0 after walk; clr_req asserted again mid-walk -> walk length unchanged.
REQ-039 Assert rst at clear cycle 8 -> next cycle clr_busy=0, all entries 8'hF0; rerun REQ-035 with DATA_W=16, ADDR_W=3, NUM_RD=4 -> top_out tracks entry 7, all four ports correct.
